demux5bit_stream: RTL and testbench
===================================

// Module: demux5bit_stream
// PURPOSE
//   Registered 1-to-2 demultiplexer: the inverse of the team's 5-bit 2:1 select mux.
//   Takes one 5-bit valid/ready input stream and steers each word to output A
//   (sel=0) or output B (sel=1).
//   Each output has a 2-entry skid buffer, so one output stalling never corrupts
//   the other. It blocks the input only while the selected output is full.
//   Sits between a shared producer (e.g. register-address source) and two consumers.
// PARAMETERS
//   WIDTH   5    data width of in/out words
//   CNT_W   16   width of transfer counters (DEMUX5_CNT_EN only)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_data    in   WIDTH  input word
//   in_sel     in   1      destination: 0 -> A, 1 -> B
//   in_valid   in   1      input word/sel valid
//   in_ready   out  1      input accepted this cycle when in_valid & in_ready
//   a_data     out  WIDTH  output A word
//   a_valid    out  1      output A word valid
//   a_ready    in   1      output A consumer ready
//   b_data     out  WIDTH  output B word
//   b_valid    out  1      output B word valid
//   b_ready    in   1      output B consumer ready
//   a_count    out  CNT_W  words delivered on A (DEMUX5_CNT_EN only)
//   b_count    out  CNT_W  words delivered on B (DEMUX5_CNT_EN only)
// BEHAVIOUR
//   - Clock/reset: one clock clk. Reset rst_n is asynchronous, active-low.
//     On assertion: both buffers empty, a_valid=b_valid=0, a_data=b_data=0,
//     counters=0. in_ready is combinational and is 0 while rst_n=0.
//   - in_ready = (in_sel ? b_cnt : a_cnt) != 2. Decided by the selected buffer's
//     registered occupancy only. No combinational path from a_ready/b_ready.
//   - Push: on in_valid & in_ready, in_data is written at the wr_ptr of the
//     selected buffer. The other buffer is untouched.
//   - Latency: a word pushed at edge N is visible on x_data/x_valid after edge N
//     when the buffer was empty. With older words queued, strict FIFO order applies.
//   - Pop: on x_valid & x_ready the head entry is retired at the edge.
//     x_data shows the head entry. x_valid = (x_cnt != 0).
//   - Buffer state per output: cnt in {0,1,2}, 1-bit wr_ptr and rd_ptr.
//     Transitions:
//       EMPTY(0) -push-> ONE(1)
//       ONE -push&pop-> ONE
//       ONE -push-> FULL(2)
//       ONE -pop-> EMPTY
//       FULL -pop-> ONE
//     No push in FULL, even with a simultaneous pop (in_ready is already 0).
//   - Pointers wrap 1->0. cnt never exceeds 2 and never goes below 0.
//   - A stalled output (ready=0, FULL) blocks only words selected for it.
//     A word for the other output passes the same cycle in_sel changes.
//   - Producer rule: while in_valid & !in_ready, the producer holds in_data and
//     in_sel stable. The block does not latch a pending request.
//   - Output rule: while x_valid & !x_ready, x_data is held stable (guaranteed).
//   - Reset mid-operation: all buffered words are discarded. No output pulses
//     after rst_n deasserts until a new push.
// CONFIGURATION
//   `DEMUX5_CNT_EN defined:
//     - a_count/b_count exist.
//     - Each counter increments by 1 on every pop of its output.
//     - Counters wrap from 2^CNT_W-1 to 0 and reset to 0.
//   `DEMUX5_CNT_EN undefined:
//     - Count ports and counter registers are absent. All other behaviour identical.
// STRUCTURE
//   - Shared package demux5_pkg:
//     - localparam BUF_DEPTH=2
//     - typedef for the buffer-count enum (EMPTY/ONE/FULL)
//     - constants SEL_A=1'b0, SEL_B=1'b1
//   - One sub-module, demux5_skid_buf: 2-entry FIFO with push/pop, cnt, head data
//     and the optional counter. demux5bit_stream instantiates it twice (A, B) and
//     adds the push-steering and in_ready logic.
// TESTING
//   1. Reset: assert rst_n=0 mid-traffic with 2 words queued on A
//      -> a_valid=b_valid=0, data=0, in_ready=0. After release, no output
//      until a new push.
//   2. Basic steer: push 5'h15 sel=0, then 5'h0A sel=1, both readies=1
//      -> a_data=15 one cycle after push 1; b_data=0A one cycle after push 2.
//   3. Full/backpressure: a_ready=0, push 01,02,03 to A
//      -> in_ready=0 on the 3rd word. Raise a_ready -> pops 01, 02; 03 then accepted.
//   4. Isolation: A full with a_ready=0, push 1F sel=1
//      -> accepted immediately, b_data=1F next cycle, A contents unchanged.
//   5. Simultaneous push/pop at cnt=1 on B, 100 back-to-back words
//      -> in_ready stays 1, one word per cycle, order preserved.
//   6. DEMUX5_CNT_EN: deliver 3 words on A and 2 on B -> a_count=3, b_count=2.
//      With CNT_W=4, deliver 17 words on A -> a_count=1.

Source files
------------

// File: rtl/demux5_pkg.sv
// Shared definitions for the 5-bit 1:2 stream demultiplexer.
// Optional feature macro: DEMUX5_CNT_EN (per-output delivery counters).
package demux5_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_cnt_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux5_skid_buf.sv
// Two-entry skid FIFO feeding one demux output; optional pop counter.
// Optional feature macro: DEMUX5_CNT_EN.
module demux5_skid_buf
    import demux5_pkg::*;
#(
    parameter int unsigned WIDTH = 5
`ifdef DEMUX5_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
`ifdef DEMUX5_CNT_EN
    ,
    output logic [CNT_W-1:0] count_o
`endif
);

    buf_cnt_e         cnt_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic             push_ok;
    logic             pop;

    // Handshake qualifiers; a push into a full buffer is never taken
    assign push_ok = push_i & (cnt_q != FULL);
    assign pop     = valid_o & ready_i;
    assign valid_o = (cnt_q != EMPTY);
    assign full_o  = (cnt_q == FULL);
    assign data_o  = mem_q[rd_ptr_q];

    // Occupancy state machine, storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (cnt_q)
                EMPTY: if (push_ok) cnt_q <= ONE;
                ONE: begin
                    if (push_ok && !pop)      cnt_q <= FULL;
                    else if (pop && !push_ok) cnt_q <= EMPTY;
                end
                FULL:    if (pop) cnt_q <= ONE;
                default: cnt_q <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX5_CNT_EN
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_d = count_q + CNT_W'(1);
    assign count_o = count_q;

    // Words delivered on this output, wrapping at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_d;
        end
    end
`endif

endmodule

// File: rtl/demux5bit_stream.sv
// Registered 1:2 valid/ready demux steering each word to output A or B.
// Optional feature macro: DEMUX5_CNT_EN (adds a_count/b_count).
module demux5bit_stream
    import demux5_pkg::*;
#(
    parameter int unsigned WIDTH = 5
`ifdef DEMUX5_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready
`ifdef DEMUX5_CNT_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;

    // Ready depends only on the selected buffer's registered occupancy
    assign in_ready = rst_n & ~((in_sel == SEL_B) ? full_b : full_a);
    assign push_a   = in_valid & in_ready & (in_sel == SEL_A);
    assign push_b   = in_valid & in_ready & (in_sel == SEL_B);

    demux5_skid_buf #(
        .WIDTH (WIDTH)
`ifdef DEMUX5_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_a),
        .data_i  (in_data),
        .ready_i (a_ready),
        .full_o  (full_a),
        .valid_o (a_valid),
        .data_o  (a_data)
`ifdef DEMUX5_CNT_EN
        ,
        .count_o (a_count)
`endif
    );

    demux5_skid_buf #(
        .WIDTH (WIDTH)
`ifdef DEMUX5_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_buf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_b),
        .data_i  (in_data),
        .ready_i (b_ready),
        .full_o  (full_b),
        .valid_o (b_valid),
        .data_o  (b_data)
`ifdef DEMUX5_CNT_EN
        ,
        .count_o (b_count)
`endif
    );

endmodule

// File: tb/tb_demux5bit_stream.sv
// Directed self-checking bench for demux5bit_stream.
// Counter checks run only when DEMUX5_CNT_EN is defined.
module tb_demux5bit_stream;

    logic       clk;
    logic       rst_n;
    logic [4:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [4:0] b_data;
    logic       b_valid;
    logic       b_ready;
    int         n_vec;
    int         n_err;

`ifdef DEMUX5_CNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
    logic [4:0]  c4_in_data;
    logic        c4_in_sel;
    logic        c4_in_valid;
    logic        c4_in_ready;
    logic [4:0]  c4_a_data;
    logic        c4_a_valid;
    logic [4:0]  c4_b_data;
    logic        c4_b_valid;
    logic [3:0]  c4_a_count;
    logic [3:0]  c4_b_count;
`endif

    demux5bit_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX5_CNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

`ifdef DEMUX5_CNT_EN
    demux5bit_stream #(.WIDTH(5), .CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (c4_in_data),
        .in_sel   (c4_in_sel),
        .in_valid (c4_in_valid),
        .in_ready (c4_in_ready),
        .a_data   (c4_a_data),
        .a_valid  (c4_a_valid),
        .a_ready  (1'b1),
        .b_data   (c4_b_data),
        .b_valid  (c4_b_valid),
        .b_ready  (1'b1),
        .a_count  (c4_a_count),
        .b_count  (c4_b_count)
    );
`endif

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        #1;
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid: got %b want 0", a_valid); end
        n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_valid: got %b want 0", b_valid); end
        n_vec++; if (a_data !== 5'h00) begin n_err++; $display("FAIL rst_a_data: got %h want 00", a_data); end
        n_vec++; if (b_data !== 5'h00) begin n_err++; $display("FAIL rst_b_data: got %h want 00", b_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 5'h03;
        cyc();
        in_data = 5'h04;
        cyc();
        in_valid = 1'b0;
        #1;
        n_vec++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_a_valid: got %b want 1", a_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pre_rst_full: got %b want 0", in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_a_valid: got %b want 0", a_valid); end
        n_vec++; if (a_data !== 5'h00) begin n_err++; $display("FAIL mid_rst_a_data: got %h want 00", a_data); end
        n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_b_valid: got %b want 0", b_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        cyc();
        rst_n = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_a_valid[%0d]: got %b want 0", i, a_valid); end
            n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_b_valid[%0d]: got %b want 0", i, b_valid); end
        end
    endtask

    task automatic test_basic_steer();
        in_valid = 1'b1; in_sel = 1'b0; in_data = 5'h15;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
        cyc();
        n_vec++; if (a_valid !== 1'b1 || a_data !== 5'h15) begin n_err++; $display("FAIL basic_a: got v=%b d=%h want v=1 d=15", a_valid, a_data); end
        in_sel = 1'b1; in_data = 5'h0A;
        cyc();
        n_vec++; if (b_valid !== 1'b1 || b_data !== 5'h0A) begin n_err++; $display("FAIL basic_b: got v=%b d=%h want v=1 d=0a", b_valid, b_data); end
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL basic_a_drained: got %b want 0", a_valid); end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL basic_b_drained: got %b want 0", b_valid); end
    endtask

    task automatic test_full();
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 5'h01;
        cyc();
        in_data = 5'h02;
        cyc();
        in_data = 5'h03;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_vec++; if (a_data !== 5'h01) begin n_err++; $display("FAIL full_head: got %h want 01", a_data); end
        cyc();
        n_vec++; if (a_valid !== 1'b1 || a_data !== 5'h01) begin n_err++; $display("FAIL full_hold: got v=%b d=%h want v=1 d=01", a_valid, a_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_still_blocked: got %b want 0", in_ready); end
        a_ready = 1'b1;
        cyc();
        n_vec++; if (a_data !== 5'h02) begin n_err++; $display("FAIL full_pop1: got %h want 02", a_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_unblock: got %b want 1", in_ready); end
        cyc();
        n_vec++; if (a_valid !== 1'b1 || a_data !== 5'h03) begin n_err++; $display("FAIL full_third: got v=%b d=%h want v=1 d=03", a_valid, a_data); end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL full_drained: got %b want 0", a_valid); end
    endtask

    task automatic test_isolation();
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 5'h11;
        cyc();
        in_data = 5'h12;
        cyc();
        in_data = 5'h13;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL iso_a_blocked: got %b want 0", in_ready); end
        in_sel = 1'b1; in_data = 5'h1F;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL iso_b_ready: got %b want 1", in_ready); end
        cyc();
        n_vec++; if (b_valid !== 1'b1 || b_data !== 5'h1F) begin n_err++; $display("FAIL iso_b: got v=%b d=%h want v=1 d=1f", b_valid, b_data); end
        n_vec++; if (a_valid !== 1'b1 || a_data !== 5'h11) begin n_err++; $display("FAIL iso_a_kept: got v=%b d=%h want v=1 d=11", a_valid, a_data); end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (b_valid !== 1'b0 || a_data !== 5'h11) begin n_err++; $display("FAIL iso_after: got bv=%b ad=%h want bv=0 ad=11", b_valid, a_data); end
        a_ready = 1'b1;
        cyc();
        n_vec++; if (a_valid !== 1'b1 || a_data !== 5'h12) begin n_err++; $display("FAIL iso_a_second: got v=%b d=%h want v=1 d=12", a_valid, a_data); end
        cyc();
        n_vec++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL iso_a_drained: got %b want 0", a_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] w;
        b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 5'((i * 7 + 3) % 32);
            in_data = w;
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            cyc();
            n_vec++; if (b_valid !== 1'b1 || b_data !== w) begin n_err++; $display("FAIL b2b_data[%0d]: got v=%b d=%h want v=1 d=%h", i, b_valid, b_data, w); end
        end
        in_valid = 1'b0;
        cyc();
        n_vec++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", b_valid); end
    endtask

`ifdef DEMUX5_CNT_EN
    task automatic test_counters();
        rst_n = 1'b0;
        #1;
        n_vec++; if (a_count !== 16'd0 || b_count !== 16'd0) begin n_err++; $display("FAIL cnt_reset: got a=%0d b=%0d want 0 0", a_count, b_count); end
        n_vec++; if (c4_a_count !== 4'd0) begin n_err++; $display("FAIL cnt4_reset: got %0d want 0", c4_a_count); end
        cyc();
        rst_n = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sel = (i >= 3); in_data = 5'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        n_vec++; if (a_count !== 16'd3) begin n_err++; $display("FAIL cnt_a: got %0d want 3", a_count); end
        n_vec++; if (b_count !== 16'd2) begin n_err++; $display("FAIL cnt_b: got %0d want 2", b_count); end
        c4_in_valid = 1'b1; c4_in_sel = 1'b0;
        for (int i = 0; i < 17; i++) begin
            c4_in_data = 5'(i);
            cyc();
        end
        c4_in_valid = 1'b0;
        cyc();
        cyc();
        n_vec++; if (c4_a_count !== 4'd1) begin n_err++; $display("FAIL cnt4_wrap: got %0d want 1", c4_a_count); end
    endtask
`endif

    initial begin
        n_vec = 0; n_err = 0;
        clk = 1'b0; rst_n = 1'b0;
        in_data = 5'h00; in_sel = 1'b0; in_valid = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
`ifdef DEMUX5_CNT_EN
        c4_in_data = 5'h00; c4_in_sel = 1'b0; c4_in_valid = 1'b0;
`endif
        test_reset();
        test_basic_steer();
        test_full();
        test_isolation();
        test_back_to_back();
`ifdef DEMUX5_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
